reg_wb_queue: RTL

REG_WB_QUEUE -- requirements
Module: reg_wb_queue

---
 rtl/reg_wb_pkg.sv | 15 +
 rtl/wb_fwd_match.sv | 31 +++
 rtl/reg_wb_queue.sv | 124 ++++++++++++
 3 files changed

// File: rtl/reg_wb_pkg.sv
// Shared types and defaults for the register write-back queue.
package reg_wb_pkg;

  localparam int XLEN_DEF  = 64;
  localparam int DEPTH_DEF = 4;

  localparam logic [4:0] REG_X0 = 5'd0;

  typedef struct packed {
    logic                valid;
    logic [4:0]          rd;
    logic [XLEN_DEF-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fwd_match.sv
// Youngest-match bypass lookup over the queued write-back entries.
module wb_fwd_match
  import reg_wb_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic [DEPTH-1:0]         valid_i,
  input  logic [DEPTH*5-1:0]       rd_flat_i,
  input  logic [DEPTH*XLEN-1:0]    data_flat_i,
  input  logic [$clog2(DEPTH)-1:0] head_i,
  input  logic [4:0]               rs_i,
  output logic                     hit_o,
  output logic [XLEN-1:0]          data_o
);

  // Walk from oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    logic match;
    int   k;
    hit_o  = 1'b0;
    data_o = {XLEN{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      k      = (int'(head_i) + i) % DEPTH;
      match  = valid_i[k] && (rd_flat_i[k*5 +: 5] == rs_i) && (rs_i != REG_X0);
      hit_o  = match ? 1'b1 : hit_o;
      data_o = match ? data_flat_i[k*XLEN +: XLEN] : data_o;
    end
  end

endmodule

// File: rtl/reg_wb_queue.sv
// Write-back queue merging ALU and long-latency results into one RF write port,
// with bypass lookup over queued entries.
module reg_wb_queue
  import reg_wb_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   mem_valid,
  output logic                   mem_ready,
  input  logic [4:0]             mem_rd,
  input  logic [XLEN-1:0]        mem_data,
  input  logic                   alu_valid,
  output logic                   alu_ready,
  input  logic [4:0]             alu_rd,
  input  logic [XLEN-1:0]        alu_data,
  output logic                   rf_wen,
  output logic [4:0]             rf_rd,
  output logic [XLEN-1:0]        rf_wd,
  input  logic [4:0]             fwd_rs1,
  input  logic [4:0]             fwd_rs2,
  output logic                   fwd_hit1,
  output logic                   fwd_hit2,
  output logic [XLEN-1:0]        fwd_data1,
  output logic [XLEN-1:0]        fwd_data2,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t         entries_q [DEPTH];
  wb_entry_t         entries_d [DEPTH];
  logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic [CW-1:0]     free_s;
  logic              mem_push_s, alu_push_s, pop_s;
  logic [PW-1:0]     alu_slot_s;
  logic [DEPTH-1:0]      valid_s;
  logic [DEPTH*5-1:0]    rd_flat_s;
  logic [DEPTH*XLEN-1:0] data_flat_s;

  // Handshake and status derived from registered occupancy only.
  always_comb begin
    free_s     = CW'(DEPTH) - count_q;
    full       = (count_q == CW'(DEPTH));
    empty      = (count_q == {CW{1'b0}});
    count      = count_q;
    mem_ready  = ~full;
    alu_ready  = (free_s >= CW'(2)) | ((free_s == CW'(1)) & ~mem_valid);
    mem_push_s = mem_valid & mem_ready & (mem_rd != REG_X0);
    alu_push_s = alu_valid & alu_ready & (alu_rd != REG_X0);
    pop_s      = ~empty;
    rf_wen     = ~empty;
    rf_rd      = empty ? REG_X0 : entries_q[head_q].rd;
    rf_wd      = empty ? {XLEN{1'b0}} : entries_q[head_q].data[XLEN-1:0];
  end

  // Next-state: pop the head, then append mem ahead of alu at the tail.
  always_comb begin
    entries_d  = entries_q;
    head_d     = head_q;
    alu_slot_s = tail_q + PW'(mem_push_s);
    if (pop_s) begin
      entries_d[head_q].valid = 1'b0;
      head_d                  = head_q + PW'(1'b1);
    end else begin
      head_d = head_q;
    end
    if (mem_push_s) begin
      entries_d[tail_q] = '{valid: 1'b1, rd: mem_rd, data: XLEN_DEF'(mem_data)};
    end else begin
      entries_d[tail_q] = entries_d[tail_q];
    end
    if (alu_push_s) begin
      entries_d[alu_slot_s] = '{valid: 1'b1, rd: alu_rd, data: XLEN_DEF'(alu_data)};
    end else begin
      entries_d[alu_slot_s] = entries_d[alu_slot_s];
    end
    tail_d  = tail_q + PW'(mem_push_s) + PW'(alu_push_s);
    count_d = count_q + CW'(mem_push_s) + CW'(alu_push_s) - CW'(pop_s);
  end

  // Queue state; reset discards all entries immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= wb_entry_t'({$bits(wb_entry_t){1'b0}});
      end
      head_q  <= {PW{1'b0}};
      tail_q  <= {PW{1'b0}};
      count_q <= {CW{1'b0}};
    end else begin
      entries_q <= entries_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
    end
  end

  // Flatten storage for the lookup instances.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      valid_s[i]                  = entries_q[i].valid;
      rd_flat_s[i*5 +: 5]         = entries_q[i].rd;
      data_flat_s[i*XLEN +: XLEN] = entries_q[i].data[XLEN-1:0];
    end
  end

  wb_fwd_match #(.XLEN(XLEN), .DEPTH(DEPTH)) u_fwd1 (
    .valid_i(valid_s), .rd_flat_i(rd_flat_s), .data_flat_i(data_flat_s),
    .head_i(head_q), .rs_i(fwd_rs1), .hit_o(fwd_hit1), .data_o(fwd_data1)
  );

  wb_fwd_match #(.XLEN(XLEN), .DEPTH(DEPTH)) u_fwd2 (
    .valid_i(valid_s), .rd_flat_i(rd_flat_s), .data_flat_i(data_flat_s),
    .head_i(head_q), .rs_i(fwd_rs2), .hit_o(fwd_hit2), .data_o(fwd_data2)
  );

endmodule
